// File: rtl/plab3_mem_line_mem_responder_pkg.sv
// Shared definitions for the line-wide memory responder: message type codes,
// field widths, FSM states and requester domain encodings.
package plab3_mem_line_mem_responder_pkg;

  localparam int unsigned MemTypeNbits = 3;
  localparam int unsigned MemAddrNbits = 32;
  localparam int unsigned MemLenNbits  = 4;
  localparam int unsigned MemDataNbits = 128;

  typedef enum logic [2:0] {
    MemRead      = 3'd0,
    MemWrite     = 3'd1,
    MemWriteInit = 3'd2
  } mem_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef enum logic {
    DomNonSecure = 1'b0,
    DomSecure    = 1'b1
  } domain_e;

  function automatic int unsigned memreq_nbits(input int unsigned opaque_nbits);
    return MemTypeNbits + opaque_nbits + MemAddrNbits + MemLenNbits + MemDataNbits;
  endfunction

  function automatic int unsigned memresp_nbits(input int unsigned opaque_nbits);
    return MemTypeNbits + opaque_nbits + MemLenNbits + MemDataNbits;
  endfunction

endpackage

// File: rtl/plab3_mem_line_mem_responder_if.sv
// Request/response bundle between a line-wide requester (master) and the
// memory responder (slave), including the requester domain and fail flag.
interface plab3_mem_line_mem_responder_if #(
  parameter int unsigned p_opaque_nbits = 8
);
  import plab3_mem_line_mem_responder_pkg::*;

  logic                                      domain;
  logic [memreq_nbits(p_opaque_nbits)-1:0]  memreq_msg;
  logic                                      memreq_val;
  logic                                      memreq_rdy;
  logic [memresp_nbits(p_opaque_nbits)-1:0] memresp_msg;
  logic                                      memresp_val;
  logic                                      memresp_rdy;
  logic                                      fail;

  modport master (
    output domain, memreq_msg, memreq_val, memresp_rdy,
    input  memreq_rdy, memresp_msg, memresp_val, fail
  );

  modport slave (
    input  domain, memreq_msg, memreq_val, memresp_rdy,
    output memreq_rdy, memresp_msg, memresp_val, fail
  );

endinterface

// File: rtl/plab3_mem_line_array.sv
// Line RAM: synchronous write, combinational read, one port of each.
// Contents have no reset and survive responder resets.
module plab3_mem_line_array #(
  parameter int unsigned p_nlines = 256,
  parameter int unsigned p_clw    = 128,
  localparam int unsigned IdxW    = $clog2(p_nlines)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [IdxW-1:0]  waddr,
  input  logic [p_clw-1:0] wdata,
  input  logic [IdxW-1:0]  raddr,
  output logic [p_clw-1:0] rdata
);

  logic [p_clw-1:0] mem_q [p_nlines];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/plab3_mem_line_mem_responder.sv
// Fixed-latency line memory responder with a secure/non-secure partition.
// Optional saturating traffic counters under PLAB3_MEM_LINE_RESP_COUNTERS_EN.
module plab3_mem_line_mem_responder
  import plab3_mem_line_mem_responder_pkg::*;
#(
  parameter int unsigned p_mem_nbytes   = 4096,
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_latency      = 2,
  parameter int unsigned p_secure_base  = 2048,
  parameter int unsigned abw            = 32,
  parameter int unsigned clw            = 128
) (
  input  logic clk,
  input  logic reset,
  plab3_mem_line_mem_responder_if.slave mem
`ifdef PLAB3_MEM_LINE_RESP_COUNTERS_EN
  ,
  output logic [15:0] num_reads,
  output logic [15:0] num_writes,
  output logic [15:0] num_fails
`endif
);

  localparam int unsigned NLines     = p_mem_nbytes / 16;
  localparam int unsigned IdxW       = $clog2(NLines);
  localparam int unsigned ReqLenLsb  = clw;
  localparam int unsigned ReqAddrLsb = clw + MemLenNbits;
  localparam int unsigned ReqOpqLsb  = ReqAddrLsb + abw;
  localparam int unsigned ReqTypeLsb = ReqOpqLsb + p_opaque_nbits;
  localparam int unsigned RespW      = MemTypeNbits + p_opaque_nbits + MemLenNbits + clw;

  logic [2:0]                req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [abw-1:0]            req_addr;
  logic [3:0]                req_len;
  logic [clw-1:0]            req_data;

  assign req_type   = mem.memreq_msg[ReqTypeLsb +: 3];
  assign req_opaque = mem.memreq_msg[ReqOpqLsb +: p_opaque_nbits];
  assign req_addr   = mem.memreq_msg[ReqAddrLsb +: abw];
  assign req_len    = mem.memreq_msg[ReqLenLsb +: 4];
  assign req_data   = mem.memreq_msg[clw-1:0];

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             rdy_q;
  logic             val_q;
  logic             fail_q;
  logic [RespW-1:0] resp_msg_q;

  logic           accept;
  logic           req_is_write;
  logic           viol;
  logic           wen;
  logic [IdxW-1:0] line_idx;
  logic [clw-1:0] rdata;
  logic [clw-1:0] resp_data;

  // rdy_q is only ever set while idle, so it doubles as the accept qualifier.
  assign accept       = rdy_q & mem.memreq_val;
  assign req_is_write = (req_type == MemWrite) || (req_type == MemWriteInit);
  assign viol         = (mem.domain == DomNonSecure) && (req_addr >= abw'(p_secure_base)) &&
                        (req_type != MemWriteInit);
  assign line_idx     = req_addr[IdxW+3:4];
  assign wen          = reset & accept & req_is_write & ~viol;

  always_comb begin
    resp_data = rdata;
    if (req_is_write || viol) begin
      resp_data = '0;
    end
  end

  plab3_mem_line_array #(
    .p_nlines (NLines),
    .p_clw    (clw)
  ) u_array (
    .clk   (clk),
    .wen   (wen),
    .waddr (line_idx),
    .wdata (req_data),
    .raddr (line_idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      val_q      <= 1'b0;
      fail_q     <= 1'b0;
      resp_msg_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            resp_msg_q <= {req_type, req_opaque, req_len, resp_data};
            fail_q     <= viol;
            rdy_q      <= 1'b0;
            if (p_latency == 0) begin
              state_q <= StResp;
              val_q   <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(p_latency - 1);
            end
          end else begin
            rdy_q <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
            val_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (mem.memresp_rdy) begin
            state_q <= StIdle;
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem.memreq_rdy  = rdy_q;
  assign mem.memresp_val = val_q;
  assign mem.memresp_msg = resp_msg_q;
  assign mem.fail        = fail_q;

`ifdef PLAB3_MEM_LINE_RESP_COUNTERS_EN
  logic [15:0] reads_q, writes_q, fails_q;
  logic [2:0]  resp_type;
  logic        resp_fire;
  logic        resp_is_write;

  assign resp_type     = resp_msg_q[RespW-1 -: 3];
  assign resp_fire     = val_q & mem.memresp_rdy;
  assign resp_is_write = (resp_type == MemWrite) || (resp_type == MemWriteInit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      reads_q  <= '0;
      writes_q <= '0;
      fails_q  <= '0;
    end else if (resp_fire) begin
      if (resp_is_write && writes_q != 16'hFFFF) writes_q <= writes_q + 16'd1;
      if (!resp_is_write && reads_q != 16'hFFFF) reads_q <= reads_q + 16'd1;
      if (fail_q && fails_q != 16'hFFFF) fails_q <= fails_q + 16'd1;
    end
  end

  assign num_reads  = reads_q;
  assign num_writes = writes_q;
  assign num_fails  = fails_q;
`endif

endmodule

// File: tb/tb_plab3_mem_line_mem_responder.sv
// Directed bench for the line memory responder: a vector table of
// transactions plus backpressure and reset-during-wait sequences.
module tb_plab3_mem_line_mem_responder;

  localparam int unsigned Latency = 2;

  typedef struct {
    logic [2:0]   t;
    logic         dom;
    logic [31:0]  a;
    logic [127:0] d;
    logic [7:0]   op;
    logic [3:0]   ln;
    logic [127:0] ed;
    logic         ef;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  plab3_mem_line_mem_responder_if #(.p_opaque_nbits(8)) bus ();

`ifdef PLAB3_MEM_LINE_RESP_COUNTERS_EN
  logic [15:0] num_reads, num_writes, num_fails;
`endif

  plab3_mem_line_mem_responder #(
    .p_mem_nbytes   (4096),
    .p_opaque_nbits (8),
    .p_latency      (Latency),
    .p_secure_base  (2048),
    .abw            (32),
    .clw            (128)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (bus)
`ifdef PLAB3_MEM_LINE_RESP_COUNTERS_EN
    ,
    .num_reads  (num_reads),
    .num_writes (num_writes),
    .num_fails  (num_fails)
`endif
  );

  localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] D2   = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] D3   = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
  localparam logic [127:0] D5   = 128'h5555_AAAA_3333_CCCC_1111_EEEE_7777_8888;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] A5   = {16{8'hA5}};

  vec_t vecs[14];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits for rdy, then drives the request for one edge.
  task automatic issue(input logic [2:0] t, input logic dom, input logic [31:0] a,
                       input logic [127:0] d, input logic [7:0] op, input logic [3:0] ln);
    int guard = 0;
    while (!bus.memreq_rdy && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.memreq_rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_rdy_timeout: got 0 expected 1");
    end
    bus.domain     = dom;
    bus.memreq_msg = {t, op, a, ln, d};
    bus.memreq_val = 1'b1;
  endtask

  // Returns the number of negedges after the accept edge until val is seen.
  task automatic wait_resp(output int lat);
    @(negedge clk);
    bus.memreq_val = 1'b0;
    lat = 1;
    while (!bus.memresp_val && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    bus.memresp_rdy = 1'b1;
    @(negedge clk);
    bus.memresp_rdy = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    issue(v.t, v.dom, v.a, v.d, v.op, v.ln);
    wait_resp(lat);
    check({tag, "_latency"}, 160'(lat), 160'(Latency + 1));
    check({tag, "_val"}, 160'(bus.memresp_val), 160'(1'b1));
    check({tag, "_type"}, 160'(bus.memresp_msg[142:140]), 160'(v.t));
    check({tag, "_opaque"}, 160'(bus.memresp_msg[139:132]), 160'(v.op));
    check({tag, "_len"}, 160'(bus.memresp_msg[131:128]), 160'(v.ln));
    check({tag, "_data"}, 160'(bus.memresp_msg[127:0]), 160'(v.ed));
    check({tag, "_fail"}, 160'(bus.fail), 160'(v.ef));
    if (bus.memresp_val) handshake();
  endtask

  initial begin
    int lat;
    logic [142:0] exp_msg;

    vecs[0]  = '{3'd1, 1'b1, 32'h100,  D1,   8'h05, 4'h0, '0, 1'b0};
    vecs[1]  = '{3'd0, 1'b1, 32'h100,  '0,   8'h11, 4'h3, D1, 1'b0};
    vecs[2]  = '{3'd1, 1'b1, 32'h900,  D2,   8'h12, 4'h0, '0, 1'b0};
    vecs[3]  = '{3'd1, 1'b0, 32'h900,  ONES, 8'h13, 4'h0, '0, 1'b1};
    vecs[4]  = '{3'd0, 1'b1, 32'h900,  '0,   8'h14, 4'h0, D2, 1'b0};
    vecs[5]  = '{3'd0, 1'b0, 32'h900,  '0,   8'h15, 4'h0, '0, 1'b1};
    vecs[6]  = '{3'd2, 1'b0, 32'h900,  A5,   8'h16, 4'h0, '0, 1'b0};
    vecs[7]  = '{3'd0, 1'b1, 32'h900,  '0,   8'h17, 4'h0, A5, 1'b0};
    vecs[8]  = '{3'd0, 1'b1, 32'h1100, '0,   8'h18, 4'h0, D1, 1'b0};
    vecs[9]  = '{3'd0, 1'b1, 32'h10C,  '0,   8'h19, 4'h0, D1, 1'b0};
    vecs[10] = '{3'd1, 1'b0, 32'h7F0,  D3,   8'h1A, 4'h0, '0, 1'b0};
    vecs[11] = '{3'd0, 1'b0, 32'h7FC,  '0,   8'h1B, 4'h0, D3, 1'b0};
    vecs[12] = '{3'd0, 1'b0, 32'h800,  '0,   8'h1C, 4'h0, '0, 1'b1};
    vecs[13] = '{3'd5, 1'b1, 32'h100,  '0,   8'h1D, 4'hF, D1, 1'b0};

    bus.domain      = 1'b0;
    bus.memreq_msg  = '0;
    bus.memreq_val  = 1'b0;
    bus.memresp_rdy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_rdy", 160'(bus.memreq_rdy), 160'(1'b0));
    check("rst_resp_val", 160'(bus.memresp_val), 160'(1'b0));
    check("rst_fail", 160'(bus.fail), 160'(1'b0));
    check("rst_resp_msg", 160'(bus.memresp_msg), 160'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rel_req_rdy", 160'(bus.memreq_rdy), 160'(1'b1));

    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: response held for 5 cycles, stray request ignored.
    issue(3'd0, 1'b1, 32'h100, '0, 8'h33, 4'h0);
    wait_resp(lat);
    exp_msg = {3'd0, 8'h33, 4'h0, D1};
    bus.domain     = 1'b0;
    bus.memreq_msg = {3'd1, 8'h44, 32'h100, 4'h0, ONES};
    bus.memreq_val = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_val", 160'(bus.memresp_val), 160'(1'b1));
      check("bp_msg", 160'(bus.memresp_msg), 160'(exp_msg));
      check("bp_fail", 160'(bus.fail), 160'(1'b0));
      check("bp_req_rdy", 160'(bus.memreq_rdy), 160'(1'b0));
      @(negedge clk);
    end
    bus.memreq_val = 1'b0;
    handshake();
    check("bp_after_val", 160'(bus.memresp_val), 160'(1'b0));
    check("bp_after_rdy", 160'(bus.memreq_rdy), 160'(1'b1));
    run_vec(14, '{3'd0, 1'b1, 32'h100, '0, 8'h34, 4'h0, D1, 1'b0});

    // Reset during WAIT: write already done at accept, response dropped.
    issue(3'd1, 1'b1, 32'h200, D5, 8'h55, 4'h0);
    @(negedge clk);
    bus.memreq_val = 1'b0;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rw_val_in_reset", 160'(bus.memresp_val), 160'(1'b0));
    end
    reset = 1'b1;
    @(negedge clk);
    check("rw_req_rdy", 160'(bus.memreq_rdy), 160'(1'b1));
    repeat (4) begin
      check("rw_val_quiet", 160'(bus.memresp_val), 160'(1'b0));
      @(negedge clk);
    end
    run_vec(15, '{3'd0, 1'b1, 32'h200, '0, 8'h56, 4'h0, D5, 1'b0});
    run_vec(16, '{3'd0, 1'b1, 32'h900, '0, 8'h57, 4'h0, A5, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
